// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit constants and injection-arbiter state type
package noc_pkg;
  localparam int FLIT_W         = 17;
  localparam int FLIT_VALID_BIT = 16;
  localparam int PAYLOAD_W      = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } inj_state_t;
endpackage

// File: rtl/noc_rr_pick.sv
// rtl/noc_rr_pick.sv - combinational round-robin picker
// First set request at or after ptr (wrapping) wins; ptr must be below N_REQ.
module noc_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       idx,
  output logic             any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = 3'(j);
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_inj_arbiter.sv
// rtl/noc_inj_arbiter.sv - round-robin router injection arbiter
// Optional stall watchdog enabled by NOC_INJ_ARB_TIMEOUT_EN.
module noc_inj_arbiter import noc_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*16-1:0]     req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]       out_flit,
  input  logic                    link_free,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    timeout_err
);
  inj_state_t           state_q, state_d;
  logic [2:0]           rr_ptr, ptr_adv, pick_ptr, pick_idx;
  logic [N_REQ-1:0]     pick_gnt, ready_raw;
  logic                 pick_any, complete, wd_fire, release_slot, accept;
  logic [PAYLOAD_W-1:0] sel_data;

  // When a held flit leaves, the search restarts just past its owner.
  assign ptr_adv      = (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
  assign complete     = (state_q == ST_HOLD) && link_free;
  assign release_slot = complete || wd_fire;
  assign pick_ptr     = (state_q == ST_HOLD) ? ptr_adv : rr_ptr;
  assign busy         = out_flit[FLIT_VALID_BIT];
  assign req_ready    = ready_raw & {N_REQ{rst_n}};

  noc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    accept    = pick_any && ((state_q == ST_IDLE) || complete);
    ready_raw = accept ? pick_gnt : '0;
    if (accept)            state_d = ST_HOLD;
    else if (release_slot) state_d = ST_IDLE;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_gnt[i]) sel_data = sel_data | req_data[i*PAYLOAD_W +: PAYLOAD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      out_flit <= '0;
    end else begin
      state_q <= state_d;
      if (release_slot) rr_ptr <= ptr_adv;
      if (accept) begin
        out_flit <= {1'b1, sel_data};
        grant_id <= pick_idx;
      end else if (release_slot) begin
        out_flit <= '0;
      end
    end
  end

`ifdef NOC_INJ_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  // Fires on the TIMEOUT-th consecutive stalled edge of one held flit.
  assign wd_fire = (state_q == ST_HOLD) && !link_free && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire;
      if ((state_q != ST_HOLD) || link_free || wd_fire) wd_cnt <= '0;
      else                                              wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT == 0);
  assign wd_fire        = 1'b0;
  assign timeout_err    = 1'b0;
`endif
endmodule

// File: tb/tb_noc_inj_arbiter.sv
// tb/tb_noc_inj_arbiter.sv - self-checking bench for noc_inj_arbiter
module tb_noc_inj_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*16-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [16:0]    out_flit;
  logic           link_free;
  logic [2:0]     grant_id;
  logic           busy, timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noc_inj_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_flit    (out_flit),
    .link_free   (link_free),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: slot occupancy, owner, payload, pointer, stall count
  bit          m_busy = 1'b0;
  bit          m_to   = 1'b0;
  int          m_gid  = 0;
  int          m_ptr  = 0;
  int          m_stall = 0;
  logic [15:0] m_pay  = '0;

  function automatic int winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (!rst_n) return r;
    if (m_busy && !link_free) return r;
    w = winner(req_valid, m_busy ? (m_gid + 1) % N : m_ptr);
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_to <= 1'b0; m_gid <= 0; m_ptr <= 0; m_stall <= 0; m_pay <= '0;
    end else begin
      automatic int          w   = -1;
      automatic int          np  = m_ptr;
      automatic int          ng  = m_gid;
      automatic int          ns  = m_stall;
      automatic bit          nb  = m_busy;
      automatic bit          nto = 1'b0;
      automatic logic [15:0] npay = m_pay;
      if (!m_busy) begin
        w = winner(req_valid, m_ptr);
      end else if (link_free) begin
        np = (m_gid + 1) % N; nb = 1'b0; ns = 0;
        w  = winner(req_valid, np);
      end else begin
`ifdef NOC_INJ_ARB_TIMEOUT_EN
        ns = m_stall + 1;
        if (ns == TO) begin
          np = (m_gid + 1) % N; nb = 1'b0; ns = 0; nto = 1'b1;
        end
`endif
      end
      if (w >= 0) begin
        nb = 1'b1; ng = w; npay = req_data[w*16 +: 16]; ns = 0;
      end
      m_busy <= nb; m_to <= nto; m_gid <= ng; m_ptr <= np; m_stall <= ns; m_pay <= npay;
    end
  end

  always @(negedge clk) begin
    chk("ready", req_ready, exp_ready());
    chk("flit_valid", out_flit[16], rst_n && m_busy);
    chk("busy", busy, rst_n && m_busy);
    chk("timeout_err", timeout_err, rst_n && m_to);
    if (!rst_n) begin
      chk("rst_flit", out_flit, 0);
      chk("rst_gid", grant_id, 0);
    end else if (m_busy) begin
      chk("payload", out_flit[15:0], m_pay);
      chk("gid", grant_id, m_gid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int n;
    bit seen1;
    req_valid = 4'hF;
    link_free = 1'b1;
    req_data  = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'h00A5};

    repeat (2) @(negedge clk);
    chk("lit_rst_ready", req_ready, 0);
    chk("lit_rst_flit", out_flit, 0);
    chk("lit_rst_busy", busy, 0);
    tick(); req_valid = '0; rst_n = 1'b1;

    // single request
    tick(); req_valid = 4'b0001; link_free = 1'b1;
    @(negedge clk); chk("lit_single_ready_c0", req_ready, 4'b0001);
    tick(); req_valid = '0;
    @(negedge clk); chk("lit_single_flit_c1", out_flit, 17'h100A5);
    chk("lit_single_gid", grant_id, 0);
    tick();
    @(negedge clk); chk("lit_single_flit_c2", out_flit[16], 0);

    // all valid, free link: back-to-back rotation
    do_reset();
    tick(); req_valid = 4'hF; link_free = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk); chk("lit_rr_order", {out_flit[16], grant_id}, {1'b1, 3'(order[k])});
    end
    tick(); req_valid = '0;
    repeat (3) tick();

    // stall with requester 2 held
    do_reset();
    tick(); req_valid = 4'b0100; link_free = 1'b0;
    @(negedge clk); chk("lit_stall_ready_c0", req_ready, 4'b0100);
    tick(); req_valid = 4'b0001;
`ifndef NOC_INJ_ARB_TIMEOUT_EN
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      chk("lit_stall_flit", out_flit, 17'h1C2C2);
      chk("lit_stall_gid", grant_id, 2);
      chk("lit_stall_ready", req_ready, 0);
      tick();
    end
    link_free = 1'b1;
    @(negedge clk); chk("lit_stall_release_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    @(negedge clk); chk("lit_stall_next", {out_flit[16], grant_id}, {1'b1, 3'd0});
`else
    n = 0;
    while (n < 20) begin
      tick(); n++;
      @(negedge clk);
      if (timeout_err) break;
    end
    chk("lit_timeout_edges", n, TO);
    chk("lit_timeout_flit_valid", out_flit[16], 0);
    chk("lit_timeout_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    @(negedge clk); chk("lit_timeout_next", {out_flit[16], grant_id, timeout_err}, {1'b1, 3'd0, 1'b0});
`endif
    tick(); link_free = 1'b1;
    repeat (3) tick();

    // reset during HOLD
    tick(); req_valid = 4'b0010; link_free = 1'b0;
    tick(); req_valid = '0;
    @(negedge clk); chk("lit_hold_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("lit_async_flit", out_flit, 0);
    chk("lit_async_busy", busy, 0);
    tick(); tick(); rst_n = 1'b1; req_valid = 4'hF; link_free = 1'b1;
    @(negedge clk); chk("lit_post_rst_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    @(negedge clk); chk("lit_post_rst_gid", {out_flit[16], grant_id}, {1'b1, 3'd0});
    repeat (3) tick();

    // requester 1 withdraws before it is ever granted
    do_reset();
    tick(); req_valid = 4'b0001; link_free = 1'b0;
    seen1 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) req_valid = 4'b0010;
      if (c == 2) req_valid = '0;
      if (c == 3) link_free = 1'b1;
      @(negedge clk);
      if (busy && grant_id == 3'd1) seen1 = 1'b1;
      if (c == 1) chk("lit_drop_hold_gid", {out_flit[16], grant_id}, {1'b1, 3'd0});
    end
    chk("lit_drop_never_granted", seen1, 0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
